cdb_arbiter: RTL

- Schedules the 3-wide Common Data Bus (CDB) among the functional units (FUs) that have finished executing.
- Each cycle it grants up to CDB_WIDTH of FU_NUM requesters, using rotating (round-robin) priority.
- It registers the winners onto the CDB, which drives the map table, the reservation stations and the ROB complete stage: CDB_tag_in, rob_complete_num.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/rr_multi_pick.sv | 38 +++
 rtl/cdb_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and widths for the CDB: slot count, ROB tag width and the broadcast packet.
// ROB_SIZE defaults to 32 when the build does not define it.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package cpu_pkg;
   localparam int CDB_WIDTH = 3;
   localparam int ROB_SIZE  = `ROB_SIZE;
   localparam int TAG_W     = $clog2(ROB_SIZE);
   localparam int XLEN      = 32;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
   } CDB_PACKET;
endpackage

// File: rtl/rr_multi_pick.sv
// Combinational pick of the first W set bits of req, scanning from ptr with wrap-around.
// Slots are filled in scan order; last_idx is the final pick, or ptr when nothing is picked.
module rr_multi_pick #(
   parameter int N  = 6,
   parameter int W  = 3,
   localparam int IW = $clog2(N),
   localparam int NW = $clog2(W + 1)
) (
   input  logic [N-1:0]          req,
   input  logic [IW-1:0]         ptr,
   output logic [N-1:0]          grant,
   output logic [W-1:0]          slot_vld,
   output logic [W-1:0][IW-1:0]  slot_idx,
   output logic [IW-1:0]         last_idx,
   output logic [NW-1:0]         num
);
   always_comb begin
      logic [IW-1:0] idx;
      logic [NW-1:0] cnt;
      grant    = '0;
      slot_vld = '0;
      slot_idx = '0;
      last_idx = ptr;
      cnt      = '0;
      idx      = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (req[idx] && (cnt < NW'(W))) begin
            grant[idx]     = 1'b1;
            slot_vld[cnt]  = 1'b1;
            slot_idx[cnt]  = idx;
            last_idx       = idx;
            cnt            = cnt + 1'b1;
         end
      end
      num = cnt;
   end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to CDB_WIDTH finished FUs per cycle onto a registered CDB.
// Optional CDB_ARB_STATS_EN adds saturating stall and broadcast counters.
module cdb_arbiter
   import cpu_pkg::*;
#(
   parameter int FU_NUM = 6,
   localparam int IW    = $clog2(FU_NUM)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [FU_NUM-1:0]                  fu_valid,
   input  logic [FU_NUM-1:0][TAG_W-1:0]       fu_tag,
   input  logic [FU_NUM-1:0][XLEN-1:0]        fu_value,
   output logic [FU_NUM-1:0]                  fu_grant,
   input  logic                               flush,
   output logic [CDB_WIDTH-1:0]               cdb_valid,
   output logic [CDB_WIDTH-1:0][TAG_W-1:0]    cdb_tag,
   output logic [CDB_WIDTH-1:0][XLEN-1:0]     cdb_value,
   output logic [1:0]                         cdb_num
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [31:0]                        stall_cnt,
   output logic [31:0]                        bcast_cnt
`endif
);
   logic [FU_NUM-1:0]               grant_raw;
   logic [CDB_WIDTH-1:0]            slot_vld;
   logic [CDB_WIDTH-1:0][IW-1:0]    slot_idx;
   logic [IW-1:0]                   last_idx;
   logic [1:0]                      pick_num;
   logic [IW-1:0]                   rr_ptr;
   CDB_PACKET [CDB_WIDTH-1:0]       pkt_nxt;

   rr_multi_pick #(.N(FU_NUM), .W(CDB_WIDTH)) u_pick (
      .req      (fu_valid),
      .ptr      (rr_ptr),
      .grant    (grant_raw),
      .slot_vld (slot_vld),
      .slot_idx (slot_idx),
      .last_idx (last_idx),
      .num      (pick_num)
   );

   // Reset and flush both suppress the handshake so no FU believes it was accepted.
   assign fu_grant = (reset || flush) ? '0 : grant_raw;

   always_comb begin
      pkt_nxt = '0;
      for (int s = 0; s < CDB_WIDTH; s++) begin
         if (slot_vld[s]) begin
            pkt_nxt[s].valid = 1'b1;
            pkt_nxt[s].tag   = fu_tag[slot_idx[s]];
            pkt_nxt[s].value = fu_value[slot_idx[s]];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_num   <= '0;
         rr_ptr    <= '0;
      end else if (flush) begin
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_num   <= '0;
         rr_ptr    <= '0;
      end else begin
         for (int s = 0; s < CDB_WIDTH; s++) begin
            cdb_valid[s] <= pkt_nxt[s].valid;
            cdb_tag[s]   <= pkt_nxt[s].tag;
            cdb_value[s] <= pkt_nxt[s].value;
         end
         cdb_num <= pick_num;
         if (|grant_raw)
            rr_ptr <= (last_idx == IW'(FU_NUM - 1)) ? '0 : last_idx + 1'b1;
      end
   end

`ifdef CDB_ARB_STATS_EN
   logic [32:0] bcast_sum;
   assign bcast_sum = {1'b0, bcast_cnt} + 33'(cdb_num);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         bcast_cnt <= '0;
      end else if (flush) begin
         stall_cnt <= '0;
         bcast_cnt <= '0;
      end else begin
         if (($countones(fu_valid) > CDB_WIDTH) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         bcast_cnt <= bcast_sum[32] ? '1 : bcast_sum[31:0];
      end
   end
`endif
endmodule
